vector_issue_stage: RTL

Decode and operand-issue stage directly upstream of the eight-lane 8-bit SIMD execution stage. Accepts 16-bit vector instructions over a valid/ready handshake, reads two 64-bit operands from an internal 8-entry vector register file, and presents a registered `{opCode, arrayA, arrayB}` bundle to the execution stage. Results return through a writeback port. A per-register scoreboard stalls issue on read-after-write and write-after-write hazards.

---
 rtl/vector_pkg.sv | 57 +++++
 rtl/vector_issue_stage_if.sv | 34 +++
 rtl/vector_regfile.sv | 52 +++++
 rtl/vector_issue_stage.sv | 114 +++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector issue path: instruction layout, width defaults,
// ALU opcode constants and register/vector typedefs.
package vector_pkg;

  localparam int BITS_OPCODE_DEF = 5;
  localparam int BITS_ARRAY_DEF  = 64;
  localparam int BITS_DATA_DEF   = 8;
  localparam int BITS_REG_DEF    = 3;
  localparam int NUM_REGS_DEF    = 1 << BITS_REG_DEF;
  localparam int NUM_LANES_DEF   = BITS_ARRAY_DEF / BITS_DATA_DEF;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RA_MSB  = 7;
  localparam int RA_LSB  = 5;
  localparam int RB_MSB  = 4;
  localparam int RB_LSB  = 2;
  localparam int RSV_MSB = 1;
  localparam int RSV_LSB = 0;

  typedef logic [BITS_REG_DEF-1:0]    reg_idx_t;
  typedef logic [BITS_ARRAY_DEF-1:0]  vec_t;
  typedef logic [BITS_OPCODE_DEF-1:0] opcode_t;

  typedef enum logic [BITS_OPCODE_DEF-1:0] {
    OP_NOP = 5'h00,
    OP_ADD = 5'h01,
    OP_SUB = 5'h02,
    OP_AND = 5'h03,
    OP_OR  = 5'h04,
    OP_XOR = 5'h05,
    OP_MIN = 5'h06,
    OP_MAX = 5'h07
  } vec_op_e;

  typedef struct packed {
    opcode_t    opcode;
    reg_idx_t   rd;
    reg_idx_t   ra;
    reg_idx_t   rb;
    logic [1:0] rsvd;
  } instr_t;

  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t d;
    d.opcode = raw[OPC_MSB:OPC_LSB];
    d.rd     = raw[RD_MSB:RD_LSB];
    d.ra     = raw[RA_MSB:RA_LSB];
    d.rb     = raw[RB_MSB:RB_LSB];
    d.rsvd   = raw[RSV_MSB:RSV_LSB];
    return d;
  endfunction

endpackage

// File: rtl/vector_issue_stage_if.sv
// Instruction, issue-bundle and writeback signals between the issue stage and its
// neighbours. slave = the issue stage, master = upstream/execution side.
interface vector_issue_stage_if
  import vector_pkg::*;
#(
  parameter int BITS_OPCODE = BITS_OPCODE_DEF,
  parameter int BITS_ARRAY  = BITS_ARRAY_DEF,
  parameter int BITS_REG    = BITS_REG_DEF
) ();

  logic                   instrValid;
  logic                   instrReady;
  logic [INSTR_W-1:0]     instr;
  logic                   issueValid;
  logic                   issueReady;
  logic [BITS_OPCODE-1:0] opCode;
  logic [BITS_ARRAY-1:0]  arrayA;
  logic [BITS_ARRAY-1:0]  arrayB;
  logic [BITS_REG-1:0]    destReg;
  logic                   wbEn;
  logic [BITS_REG-1:0]    wbReg;
  logic [BITS_ARRAY-1:0]  wbData;

  modport slave (
    input  instrValid, instr, issueReady, wbEn, wbReg, wbData,
    output instrReady, issueValid, opCode, arrayA, arrayB, destReg
  );

  modport master (
    output instrValid, instr, issueReady, wbEn, wbReg, wbData,
    input  instrReady, issueValid, opCode, arrayA, arrayB, destReg
  );

endinterface

// File: rtl/vector_regfile.sv
// Vector register file: R0 hard-wired to zero, two async read ports, one write port.
// With VECTOR_ISSUE_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module vector_regfile
  import vector_pkg::*;
#(
  parameter int BITS_ARRAY = BITS_ARRAY_DEF,
  parameter int BITS_REG   = BITS_REG_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [BITS_REG-1:0]   waddr,
  input  logic [BITS_ARRAY-1:0] wdata,
  input  logic [BITS_REG-1:0]   raddr_a,
  output logic [BITS_ARRAY-1:0] rdata_a,
  input  logic [BITS_REG-1:0]   raddr_b,
  output logic [BITS_ARRAY-1:0] rdata_b
);

  localparam int NREGS = 1 << BITS_REG;

  logic [BITS_ARRAY-1:0] regs [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_file
        logic [BITS_ARRAY-1:0] q_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q_reg <= '0;
          end else if (we && (waddr == BITS_REG'(gi))) begin
            q_reg <= wdata;
          end
        end
        assign regs[gi] = q_reg;
      end
    end
  endgenerate

`ifdef VECTOR_ISSUE_BYPASS_EN
  // R0 must stay zero even while it is the write target
  assign rdata_a = (we && (waddr == raddr_a) && (raddr_a != '0)) ? wdata : regs[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b) && (raddr_b != '0)) ? wdata : regs[raddr_b];
`else
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
`endif

endmodule

// File: rtl/vector_issue_stage.sv
// Decode/operand-issue stage: scoreboarded register reads feeding a registered bundle.
// VECTOR_ISSUE_BYPASS_EN enables same-cycle writeback clear and operand forwarding.
module vector_issue_stage
  import vector_pkg::*;
#(
  parameter int BITS_OPCODE = BITS_OPCODE_DEF,
  parameter int BITS_ARRAY  = BITS_ARRAY_DEF,
  parameter int BITS_REG    = BITS_REG_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_issue_stage_if.slave  bus,
  output logic                 illegalSeen,
  output logic [15:0]          issueCount
);

  localparam int NREGS = 1 << BITS_REG;

  instr_t                dec;
  logic [NREGS-1:0]      pending_reg;
  logic [NREGS-1:0]      pending_next;
  logic [NREGS-1:0]      pending_eff;
  logic [NREGS-1:0]      wb_clr;
  logic [NREGS-1:0]      rd_set;
  logic                  hazard;
  logic                  instr_ready;
  logic                  accept;
  logic [BITS_ARRAY-1:0] rdata_a;
  logic [BITS_ARRAY-1:0] rdata_b;

  logic                   issue_valid_reg;
  logic [BITS_OPCODE-1:0] opcode_reg;
  logic [BITS_ARRAY-1:0]  array_a_reg;
  logic [BITS_ARRAY-1:0]  array_b_reg;
  logic [BITS_REG-1:0]    dest_idx_reg;
  logic                   illegal_reg;
  logic [15:0]            count_reg;

  assign dec = decode_instr(bus.instr);

  // R0 never takes part in the scoreboard
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_sb
      assign wb_clr[gi] = bus.wbEn && (bus.wbReg == BITS_REG'(gi)) && (gi != 0);
      assign rd_set[gi] = accept && (dec.rd == BITS_REG'(gi)) && (gi != 0);
    end
  endgenerate

`ifdef VECTOR_ISSUE_BYPASS_EN
  assign pending_eff = pending_reg & ~wb_clr;
`else
  assign pending_eff = pending_reg;
`endif

  assign hazard       = pending_eff[dec.ra] | pending_eff[dec.rb] | pending_eff[dec.rd];
  assign instr_ready  = rst_n && !hazard && (!issue_valid_reg || bus.issueReady);
  assign accept       = bus.instrValid && instr_ready;
  // a set in the same cycle as a clear of the same register wins
  assign pending_next = (pending_reg & ~wb_clr) | rd_set;

  vector_regfile #(
    .BITS_ARRAY (BITS_ARRAY),
    .BITS_REG   (BITS_REG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (bus.wbEn),
    .waddr   (bus.wbReg),
    .wdata   (bus.wbData),
    .raddr_a (dec.ra),
    .rdata_a (rdata_a),
    .raddr_b (dec.rb),
    .rdata_b (rdata_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg     <= '0;
      issue_valid_reg <= 1'b0;
      opcode_reg      <= '0;
      array_a_reg     <= '0;
      array_b_reg     <= '0;
      dest_idx_reg    <= '0;
      illegal_reg     <= 1'b0;
      count_reg       <= '0;
    end else begin
      pending_reg <= pending_next;
      if (accept) begin
        issue_valid_reg <= 1'b1;
        opcode_reg      <= dec.opcode;
        array_a_reg     <= rdata_a;
        array_b_reg     <= rdata_b;
        dest_idx_reg    <= dec.rd;
        count_reg       <= count_reg + 16'd1;
        if (dec.rsvd != 2'b00) begin
          illegal_reg <= 1'b1;
        end
      end else if (bus.issueReady) begin
        issue_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.instrReady = instr_ready;
  assign bus.issueValid = issue_valid_reg;
  assign bus.opCode     = opcode_reg;
  assign bus.arrayA     = array_a_reg;
  assign bus.arrayB     = array_b_reg;
  assign bus.destReg    = dest_idx_reg;
  assign illegalSeen    = illegal_reg;
  assign issueCount     = count_reg;

endmodule
